rdma_tx_pkt_arbiter: RTL and testbench

- Packet-granular, two-input round-robin arbiter that merges the ERNIC RoCE TX stream (port 0) and the host non-RoCE TX stream (port 1) onto the single CMAC TX AXI-Stream.
- A grant is held from the first beat to tlast, so packets are never interleaved.
- The output is a registered 2-entry skid buffer.
- Per-source 32-bit packet counters and a source tag give debug visibility.

---
 rtl/rdma_tx_pkt_arbiter.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_rdma_tx_pkt_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdma_tx_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// rdma_tx_pkt_arbiter
//
// Packet-granular two-input round-robin arbiter. It merges the ERNIC RoCE TX
// stream (port 0) and the host non-RoCE TX stream (port 1) onto the single CMAC
// TX AXI-Stream. A grant is held from the first beat of a packet through its
// tlast, so packets from the two sources are never interleaved. The output
// stage is a registered 2-entry (main + skid) buffer. Per-source packet
// counters and a source tag (m_axis_tid) provide debug visibility.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   s0_axis_*            RoCE TX stream in (tdata/tkeep/tlast/tuser/tvalid/tready)
//   s1_axis_*            non-RoCE TX stream in (same shape as s0)
//   m_axis_*             merged stream out to CMAC; tid = source (0 RoCE, 1 other)
//   roce_pkt_cnt         packets emitted from port 0 (wraps)
//   other_pkt_cnt        packets emitted from port 1 (wraps)
// -----------------------------------------------------------------------------
module rdma_tx_pkt_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic                  s0_axis_tlast,
    input  logic                  s0_axis_tuser,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,

    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic                  s1_axis_tlast,
    input  logic                  s1_axis_tuser,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tid,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,

    output logic [CNT_WIDTH-1:0]  roce_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  other_pkt_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PKT  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Arbitration state
    logic [0:0]            state_r;
    logic [0:0]            state_nxt_s;
    logic                  grant_r;
    logic                  grant_nxt_s;
    logic                  last_grant_r;
    logic                  last_grant_nxt_s;

    // Output buffer: main entry drives m_axis directly, skid absorbs one beat
    logic                  main_valid_r;
    logic [DATA_WIDTH-1:0] main_data_r;
    logic [KEEP_WIDTH-1:0] main_keep_r;
    logic                  main_last_r;
    logic                  main_user_r;
    logic                  main_tid_r;

    logic                  skid_full_r;
    logic [DATA_WIDTH-1:0] skid_data_r;
    logic [KEEP_WIDTH-1:0] skid_keep_r;
    logic                  skid_last_r;
    logic                  skid_user_r;
    logic                  skid_tid_r;

    logic [CNT_WIDTH-1:0]  roce_cnt_r;
    logic [CNT_WIDTH-1:0]  other_cnt_r;

    // Selected (granted) input beat
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [KEEP_WIDTH-1:0] sel_keep_s;
    logic                  sel_last_s;
    logic                  sel_user_s;
    logic                  sel_valid_s;

    logic                  in_pkt_s;
    logic                  accept_s;
    logic                  m_hs_s;

    logic                  load_main_in_s;
    logic                  load_main_skid_s;
    logic                  load_skid_s;
    logic                  main_valid_nxt_s;
    logic                  skid_full_nxt_s;

    // tready depends only on registers, so no combinational path from m_axis_tready
    assign in_pkt_s       = (state_r == S_PKT);
    assign s0_axis_tready = in_pkt_s && (grant_r == 1'b0) && !skid_full_r;
    assign s1_axis_tready = in_pkt_s && (grant_r == 1'b1) && !skid_full_r;

    assign m_axis_tdata   = main_data_r;
    assign m_axis_tkeep   = main_keep_r;
    assign m_axis_tlast   = main_last_r;
    assign m_axis_tuser   = main_user_r;
    assign m_axis_tid     = main_tid_r;
    assign m_axis_tvalid  = main_valid_r;

    assign roce_pkt_cnt   = roce_cnt_r;
    assign other_pkt_cnt  = other_cnt_r;

    assign m_hs_s   = main_valid_r && m_axis_tready;
    assign accept_s = in_pkt_s && sel_valid_s && !skid_full_r;

    // Input mux driven by the registered grant
    always_comb begin
        sel_data_s  = s0_axis_tdata;
        sel_keep_s  = s0_axis_tkeep;
        sel_last_s  = s0_axis_tlast;
        sel_user_s  = s0_axis_tuser;
        sel_valid_s = s0_axis_tvalid;
        if (grant_r == 1'b1) begin
            sel_data_s  = s1_axis_tdata;
            sel_keep_s  = s1_axis_tkeep;
            sel_last_s  = s1_axis_tlast;
            sel_user_s  = s1_axis_tuser;
            sel_valid_s = s1_axis_tvalid;
        end else begin
            sel_valid_s = s0_axis_tvalid;
        end
    end

    // Arbitration FSM next-state: one idle cycle to decide, then hold to tlast
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        case (state_r)
            S_IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid) begin
                    // Both requesting: alternate away from the previous winner
                    grant_nxt_s = ~last_grant_r;
                    state_nxt_s = S_PKT;
                end else if (s0_axis_tvalid) begin
                    grant_nxt_s = 1'b0;
                    state_nxt_s = S_PKT;
                end else if (s1_axis_tvalid) begin
                    grant_nxt_s = 1'b1;
                    state_nxt_s = S_PKT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_PKT: begin
                if (accept_s && sel_last_s) begin
                    last_grant_nxt_s = grant_r;
                    state_nxt_s      = S_IDLE;
                end else begin
                    state_nxt_s = S_PKT;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Skid buffer control: skid refills main first; new beats land in main
    // when it is empty or draining, otherwise in skid
    always_comb begin
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        main_valid_nxt_s = main_valid_r;
        skid_full_nxt_s  = skid_full_r;
        if (m_hs_s && skid_full_r) begin
            // tready is low while skid is full, so no beat is accepted here
            load_main_skid_s = 1'b1;
            main_valid_nxt_s = 1'b1;
            skid_full_nxt_s  = 1'b0;
        end else if (accept_s && (!main_valid_r || m_hs_s)) begin
            load_main_in_s   = 1'b1;
            main_valid_nxt_s = 1'b1;
        end else if (accept_s) begin
            load_skid_s      = 1'b1;
            skid_full_nxt_s  = 1'b1;
        end else if (m_hs_s) begin
            main_valid_nxt_s = 1'b0;
        end else begin
            main_valid_nxt_s = main_valid_r;
        end
    end

    // FSM and grant registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
        end
    end

    // Main output entry
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            main_data_r  <= {DATA_WIDTH{1'b0}};
            main_keep_r  <= {KEEP_WIDTH{1'b0}};
            main_last_r  <= 1'b0;
            main_user_r  <= 1'b0;
            main_tid_r   <= 1'b0;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            if (load_main_skid_s) begin
                main_data_r <= skid_data_r;
                main_keep_r <= skid_keep_r;
                main_last_r <= skid_last_r;
                main_user_r <= skid_user_r;
                main_tid_r  <= skid_tid_r;
            end else if (load_main_in_s) begin
                main_data_r <= sel_data_s;
                main_keep_r <= sel_keep_s;
                main_last_r <= sel_last_s;
                main_user_r <= sel_user_s;
                main_tid_r  <= grant_r;
            end else begin
                main_data_r <= main_data_r;
            end
        end
    end

    // Skid entry
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_full_r <= 1'b0;
            skid_data_r <= {DATA_WIDTH{1'b0}};
            skid_keep_r <= {KEEP_WIDTH{1'b0}};
            skid_last_r <= 1'b0;
            skid_user_r <= 1'b0;
            skid_tid_r  <= 1'b0;
        end else begin
            skid_full_r <= skid_full_nxt_s;
            if (load_skid_s) begin
                skid_data_r <= sel_data_s;
                skid_keep_r <= sel_keep_s;
                skid_last_r <= sel_last_s;
                skid_user_r <= sel_user_s;
                skid_tid_r  <= grant_r;
            end else begin
                skid_data_r <= skid_data_r;
            end
        end
    end

    // Packet counters: count on the output handshake of each tlast beat
    always_ff @(posedge clk) begin
        if (rst) begin
            roce_cnt_r  <= {CNT_WIDTH{1'b0}};
            other_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (m_hs_s && main_last_r) begin
            if (main_tid_r == 1'b0) begin
                roce_cnt_r <= roce_cnt_r + CNT_ONE;
            end else begin
                other_cnt_r <= other_cnt_r + CNT_ONE;
            end
        end else begin
            roce_cnt_r  <= roce_cnt_r;
            other_cnt_r <= other_cnt_r;
        end
    end

endmodule

// File: tb/tb_rdma_tx_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rdma_tx_pkt_arbiter
//
// Scoreboard bench: every beat accepted on an input port is pushed, tagged with
// its source, into an expected queue; the output monitor pops and compares each
// m_axis handshake. Output tids and handshake cycle stamps are logged so the
// directed tests can check arbitration order and bubble timing. A narrow
// counter width is used so the wrap case is reachable by real traffic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rdma_tx_pkt_arbiter;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int CW = 8;
    localparam int BW = DW + KW + 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic [DW-1:0] sd [2];
    logic [KW-1:0] sk [2];
    logic          sl [2];
    logic          su [2];
    logic          sv [2];
    logic          s0_tready;
    logic          s1_tready;

    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tuser;
    logic          m_tid;
    logic          m_tvalid;
    logic          m_tready = 1'b1;

    logic [CW-1:0] roce_cnt;
    logic [CW-1:0] other_cnt;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;

    logic [BW-1:0] exp_q [$];
    logic          out_tid [$];
    int            out_stamp [$];

    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_bus = '0;

    rdma_tx_pkt_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .s0_axis_tdata  (sd[0]),
        .s0_axis_tkeep  (sk[0]),
        .s0_axis_tlast  (sl[0]),
        .s0_axis_tuser  (su[0]),
        .s0_axis_tvalid (sv[0]),
        .s0_axis_tready (s0_tready),
        .s1_axis_tdata  (sd[1]),
        .s1_axis_tkeep  (sk[1]),
        .s1_axis_tlast  (sl[1]),
        .s1_axis_tuser  (su[1]),
        .s1_axis_tvalid (sv[1]),
        .s1_axis_tready (s1_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tlast   (m_tlast),
        .m_axis_tuser   (m_tuser),
        .m_axis_tid     (m_tid),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .roce_pkt_cnt   (roce_cnt),
        .other_pkt_cnt  (other_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                                input logic u, input logic l, input logic t);
        return {d, k, 5'b00000, u, l, t};
    endfunction

    function automatic logic port_ready(input int p);
        return (p == 0) ? s0_tready : s1_tready;
    endfunction

    // Output monitor: scoreboard compare, hold-stability check, tid/stamp log
    always @(negedge clk) begin
        logic [BW-1:0] obs;
        obs = pack_beat(m_tdata, m_tkeep, m_tuser, m_tlast, m_tid);
        if (!rst) begin
            if (prev_stall) check_eq("hold_stable", obs, prev_bus);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) check_eq("unexpected_beat", obs, '0);
                else check_eq("beat", obs, exp_q.pop_front());
                out_tid.push_back(m_tid);
                out_stamp.push_back(cyc);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_bus   = obs;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Drive one packet on port p; expected beats are queued on each input handshake
    task automatic send_pkt(input int p, input int n, input logic [7:0] base, input logic usr);
        for (int b = 0; b < n; b++) begin
            int waited;
            logic [7:0] tag;
            waited = 0;
            tag    = base + 8'(b);
            sd[p]  = {16{24'hC0FFEE, tag}};
            sk[p]  = (b == n - 1) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
            sl[p]  = (b == n - 1);
            su[p]  = (b == n - 1) ? usr : 1'b0;
            sv[p]  = 1'b1;
            @(negedge clk);
            while (!port_ready(p) && waited < 200) begin
                waited++;
                @(negedge clk);
            end
            if (waited >= 200) begin
                check_eq("s_ready_timeout", BW'(0), BW'(1));
                sv[p] = 1'b0;
                return;
            end
            exp_q.push_back(pack_beat(sd[p], sk[p], su[p], sl[p], p[0]));
            @(posedge clk);
            #1;
        end
        sv[p] = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_eq("drain_timeout", BW'(0), BW'(1));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        sv[0] = 1'b0;
        sv[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        out_tid.delete();
        out_stamp.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int p = 0; p < 2; p++) begin
            sd[p] = '0; sk[p] = '0; sl[p] = 1'b0; su[p] = 1'b0; sv[p] = 1'b0;
        end

        // Reset state, sampled while reset is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_m_tvalid", BW'(m_tvalid), BW'(0));
        check_eq("rst_m_tdata", BW'(m_tdata), BW'(0));
        check_eq("rst_m_tid", BW'(m_tid), BW'(0));
        check_eq("rst_s0_tready", BW'(s0_tready), BW'(0));
        check_eq("rst_s1_tready", BW'(s1_tready), BW'(0));
        check_eq("rst_roce_cnt", BW'(roce_cnt), BW'(0));
        check_eq("rst_other_cnt", BW'(other_cnt), BW'(0));
        do_reset();

        // Basic pass-through: 3-beat port-0 packet, first output 2 cycles later
        t0 = cyc;
        send_pkt(0, 3, 8'hA0, 1'b1);
        wait_drain();
        check_eq("basic_count", BW'(out_stamp.size()), BW'(3));
        if (out_stamp.size() > 0) check_eq("basic_latency", BW'(out_stamp[0] - t0), BW'(2));
        check_eq("basic_roce_cnt", BW'(roce_cnt), BW'(1));
        check_eq("basic_other_cnt", BW'(other_cnt), BW'(0));

        // Round robin: both ports continuously offer 2-beat packets
        do_reset();
        fork
            for (int k = 0; k < 4; k++) send_pkt(0, 2, 8'h10 + 8'(2 * k), 1'b0);
            for (int k = 0; k < 4; k++) send_pkt(1, 2, 8'h50 + 8'(2 * k), 1'b1);
        join
        wait_drain();
        check_eq("rr_count", BW'(out_tid.size()), BW'(16));
        for (int i = 0; i < out_tid.size() && i < 16; i++)
            check_eq("rr_tid", BW'(out_tid[i]), BW'((i / 2) % 2));
        for (int i = 1; i < out_stamp.size() && i < 16; i++)
            check_eq("rr_gap", BW'(out_stamp[i] - out_stamp[i-1]), BW'((i % 2 == 1) ? 1 : 2));
        check_eq("rr_roce_cnt", BW'(roce_cnt), BW'(4));
        check_eq("rr_other_cnt", BW'(other_cnt), BW'(4));

        // Backpressure: m_tready low for 5 edges while beat 2 of 4 is presented
        do_reset();
        fork
            send_pkt(1, 4, 8'hB0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 m_tready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i >= 1) check_eq("bp_s1_tready", BW'(s1_tready), BW'(0));
                end
                @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join
        wait_drain();
        check_eq("bp_count", BW'(out_stamp.size()), BW'(4));
        if (out_stamp.size() == 4) begin
            check_eq("bp_stall_len", BW'(out_stamp[1] - out_stamp[0]), BW'(6));
            check_eq("bp_b2b_3", BW'(out_stamp[2] - out_stamp[1]), BW'(1));
            check_eq("bp_b2b_4", BW'(out_stamp[3] - out_stamp[2]), BW'(1));
        end
        check_eq("bp_other_cnt", BW'(other_cnt), BW'(1));

        // Single-beat storm on port 1
        do_reset();
        for (int k = 0; k < 10; k++) send_pkt(1, 1, 8'h60 + 8'(k), k[0]);
        wait_drain();
        check_eq("storm_count", BW'(out_stamp.size()), BW'(10));
        for (int i = 1; i < out_stamp.size(); i++)
            check_eq("storm_gap", BW'(out_stamp[i] - out_stamp[i-1]), BW'(2));
        check_eq("storm_other_cnt", BW'(other_cnt), BW'(10));
        check_eq("storm_roce_cnt", BW'(roce_cnt), BW'(0));

        // Reset mid-packet: rst on beat 2 of a 5-beat port-0 packet
        do_reset();
        sd[0] = {16{32'hD0D0_D000}}; sk[0] = '1; sl[0] = 1'b0; su[0] = 1'b0; sv[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sd[0] = {16{32'hD0D0_D001}};
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        sv[0] = 1'b0;
        exp_q.delete();
        out_tid.delete();
        out_stamp.delete();
        @(negedge clk);
        check_eq("mid_rst_m_tvalid", BW'(m_tvalid), BW'(0));
        check_eq("mid_rst_roce_cnt", BW'(roce_cnt), BW'(0));
        check_eq("mid_rst_other_cnt", BW'(other_cnt), BW'(0));
        check_eq("mid_rst_idle_s0", BW'(s0_tready), BW'(0));
        @(posedge clk);
        #1;
        fork
            send_pkt(0, 2, 8'hE0, 1'b0);
            send_pkt(1, 2, 8'hF0, 1'b0);
        join
        wait_drain();
        check_eq("post_rst_count", BW'(out_tid.size()), BW'(4));
        if (out_tid.size() == 4) begin
            check_eq("post_rst_first", BW'(out_tid[0]), BW'(0));
            check_eq("post_rst_second", BW'(out_tid[2]), BW'(1));
        end
        check_eq("post_rst_roce_cnt", BW'(roce_cnt), BW'(1));
        check_eq("post_rst_other_cnt", BW'(other_cnt), BW'(1));

        // Counter wrap: drive roce count to all-ones with real packets, then one more
        do_reset();
        for (int k = 0; k < 255; k++) send_pkt(0, 1, 8'(k), 1'b0);
        wait_drain();
        check_eq("wrap_roce_max", BW'(roce_cnt), BW'(8'hFF));
        send_pkt(1, 1, 8'h77, 1'b1);
        wait_drain();
        check_eq("wrap_other_pre", BW'(other_cnt), BW'(1));
        send_pkt(0, 1, 8'h88, 1'b0);
        wait_drain();
        check_eq("wrap_roce_zero", BW'(roce_cnt), BW'(0));
        check_eq("wrap_other_same", BW'(other_cnt), BW'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
